// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and flush.
// Optional macro ID_EX_BUBBLE_CNT_EN builds the bubble counter.
module id_ex_stage_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_RegWr,
  input  logic          id_RegDst,
  input  logic          id_ExtOp,
  input  logic          id_AluSrc,
  input  logic          id_MemWr,
  input  logic          id_MemtoReg,
  input  logic          id_Branch,
  input  logic [2:0]    id_ALUop,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_busA,
  input  logic [DW-1:0] id_busB,
  input  logic [15:0]   id_imm16,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  output logic          hazard_stall,
  output logic          ex_RegWr,
  output logic          ex_ExtOp,
  output logic          ex_AluSrc,
  output logic          ex_MemWr,
  output logic          ex_MemtoReg,
  output logic          ex_Branch,
  output logic [2:0]    ex_ALUop,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_busA,
  output logic [DW-1:0] ex_busB,
  output logic [DW-1:0] ex_imm32,
  output logic [5:0]    ex_funct,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_wreg,
  output logic          ex_valid,
  output logic [15:0]   bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic          reg_wr;
    logic          ext_op;
    logic          alu_src;
    logic          mem_wr;
    logic          memto_reg;
    logic          branch;
    logic [2:0]    alu_op;
    logic [DW-1:0] pc4;
    logic [DW-1:0] bus_a;
    logic [DW-1:0] bus_b;
    logic [DW-1:0] imm32;
    logic [5:0]    funct;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wreg;
  } ex_t;

  ex_t  ex_q, ex_d, cap;
  logic id_uses_rt;
  logic hazard;

  // load-use detect against the load currently in EX
  always_comb begin
    id_uses_rt = id_RegDst | id_MemWr | id_Branch;
    hazard = ex_q.valid & ex_q.memto_reg & ex_q.reg_wr
           & (ex_q.rt != '0)
           & ((ex_q.rt == id_rs)
             | ((ex_q.rt == id_rt) & id_uses_rt));
    hazard_stall = hazard & ~flush & ~hold;
  end

  // decoded ID instruction as it would appear in EX
  always_comb begin
    cap = '0;
    cap.valid = 1'b1;
    cap.reg_wr = id_RegWr;
    cap.ext_op = id_ExtOp;
    cap.alu_src = id_AluSrc;
    cap.mem_wr = id_MemWr;
    cap.memto_reg = id_MemtoReg;
    cap.branch = id_Branch;
    cap.alu_op = id_ALUop;
    cap.pc4 = id_pc4;
    cap.bus_a = id_busA;
    cap.bus_b = id_busB;
    cap.imm32 = {{(DW-16){id_ExtOp & id_imm16[15]}}, id_imm16};
    cap.funct = id_funct;
    cap.rs = id_rs;
    cap.rt = id_rt;
    cap.wreg = id_RegDst ? id_rd : id_rt;
  end

  // next EX contents: reset > hold > bubble > capture
  always_comb begin
    ex_d = ex_q;
    if (rst) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (flush | hazard) begin
      ex_d = '0;
    end else begin
      ex_d = cap;
    end
  end

  // EX stage register
  always_ff @(posedge clk) begin
    ex_q <= ex_d;
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // saturating count of flush/hazard bubbles
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (rst) begin
      bubble_cnt_d = '0;
    end else if (!hold && (flush || hazard)
                 && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // bubble counter register
  always_ff @(posedge clk) begin
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = '0;
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_RegWr    = ex_q.reg_wr;
  assign ex_ExtOp    = ex_q.ext_op;
  assign ex_AluSrc   = ex_q.alu_src;
  assign ex_MemWr    = ex_q.mem_wr;
  assign ex_MemtoReg = ex_q.memto_reg;
  assign ex_Branch   = ex_q.branch;
  assign ex_ALUop    = ex_q.alu_op;
  assign ex_pc4      = ex_q.pc4;
  assign ex_busA     = ex_q.bus_a;
  assign ex_busB     = ex_q.bus_b;
  assign ex_imm32    = ex_q.imm32;
  assign ex_funct    = ex_q.funct;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_wreg     = ex_q.wreg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed MIPS sequences,
// expected EX state and hazard_stall queued per cycle.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic        ext_op;
    logic        alu_src;
    logic        mem_wr;
    logic        memto_reg;
    logic        branch;
    logic [2:0]  alu_op;
    logic [31:0] pc4;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] imm32;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
  } st_t;

  typedef struct {
    st_t         st;
    logic        hs;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, hold = 1'b0, flush = 1'b0;
  logic id_RegWr = 0, id_RegDst = 0, id_ExtOp = 0, id_AluSrc = 0;
  logic id_MemWr = 0, id_MemtoReg = 0, id_Branch = 0;
  logic [2:0]  id_ALUop = '0;
  logic [31:0] id_pc4 = '0, id_busA = '0, id_busB = '0;
  logic [15:0] id_imm16 = '0;
  logic [5:0]  id_funct = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;

  logic        hazard_stall;
  logic        ex_RegWr, ex_ExtOp, ex_AluSrc, ex_MemWr;
  logic        ex_MemtoReg, ex_Branch, ex_valid;
  logic [2:0]  ex_ALUop;
  logic [31:0] ex_pc4, ex_busA, ex_busB, ex_imm32;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic [15:0] bubble_cnt;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_RegWr(id_RegWr), .id_RegDst(id_RegDst),
    .id_ExtOp(id_ExtOp), .id_AluSrc(id_AluSrc),
    .id_MemWr(id_MemWr), .id_MemtoReg(id_MemtoReg),
    .id_Branch(id_Branch), .id_ALUop(id_ALUop),
    .id_pc4(id_pc4), .id_busA(id_busA), .id_busB(id_busB),
    .id_imm16(id_imm16), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .hazard_stall(hazard_stall),
    .ex_RegWr(ex_RegWr), .ex_ExtOp(ex_ExtOp),
    .ex_AluSrc(ex_AluSrc), .ex_MemWr(ex_MemWr),
    .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
    .ex_ALUop(ex_ALUop), .ex_pc4(ex_pc4),
    .ex_busA(ex_busA), .ex_busB(ex_busB),
    .ex_imm32(ex_imm32), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cexp(input int n);
`ifdef ID_EX_BUBBLE_CNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  // c = {RegWr,ExtOp,AluSrc,MemWr,MemtoReg,Branch}
  function automatic st_t ev(
    input logic [5:0] c, input logic [2:0] alu,
    input logic [31:0] pc4, a, b, imm,
    input logic [5:0] fn, input logic [4:0] rs, rt, wr);
    return {1'b1, c, alu, pc4, a, b, imm, fn, rs, rt, wr};
  endfunction

  // c = {RegWr,RegDst,ExtOp,AluSrc,MemWr,MemtoReg,Branch}
  task automatic setid(
    input logic [6:0] c, input logic [2:0] alu,
    input logic [31:0] pc4, a, b, input logic [15:0] imm,
    input logic [4:0] rs, rt, rd);
    {id_RegWr, id_RegDst, id_ExtOp, id_AluSrc,
     id_MemWr, id_MemtoReg, id_Branch} = c;
    id_ALUop = alu;
    id_pc4 = pc4;
    id_busA = a;
    id_busB = b;
    id_imm16 = imm;
    id_funct = imm[5:0];
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input logic r, h, f, input st_t st,
    input logic hs, input logic [15:0] cnt);
    exp_t e;
    rst = r;
    hold = h;
    flush = f;
    e.st = st;
    e.hs = hs;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  // monitor: compare DUT against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      st_t act;
      e = q.pop_front();
      act = {ex_valid, ex_RegWr, ex_ExtOp, ex_AluSrc, ex_MemWr,
             ex_MemtoReg, ex_Branch, ex_ALUop, ex_pc4, ex_busA,
             ex_busB, ex_imm32, ex_funct, ex_rs, ex_rt, ex_wreg};
      n_chk++;
      if (hazard_stall !== e.hs) begin
        n_fail++;
        $display("FAIL hazard_stall t=%0t got %b exp %b",
                 $time, hazard_stall, e.hs);
      end
      n_chk++;
      if (act !== e.st) begin
        n_fail++;
        $display("FAIL ex_state t=%0t got %h exp %h",
                 $time, act, e.st);
      end
      n_chk++;
      if (bubble_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL bubble_cnt t=%0t got %h exp %h",
                 $time, bubble_cnt, e.cnt);
      end
    end
  end

  initial begin
    st_t z, e_addi, e_ori5, e_add, e_lw0, e_ori3;
    st_t e_lw4, e_ori4, e_beq;
    z = '0;
    e_addi = ev(6'b111000, 3'd0, 32'h104, 32'h11, 32'h22,
                32'hFFFF_FFFC, 6'h3C, 5'd9, 5'd8, 5'd8);
    e_ori5 = ev(6'b101000, 3'd3, 32'h108, 32'h33, 32'h44,
                32'h0000_8001, 6'h01, 5'd1, 5'd5, 5'd5);
    e_add  = ev(6'b100000, 3'd2, 32'h110, 32'h77, 32'h88,
                32'h0000_3020, 6'h20, 5'd5, 5'd7, 5'd6);
    e_lw0  = ev(6'b111010, 3'd0, 32'h114, 32'h99, 32'h0,
                32'h0, 6'h00, 5'd3, 5'd0, 5'd0);
    e_ori3 = ev(6'b101000, 3'd3, 32'h118, 32'h0, 32'hAA,
                32'h1, 6'h01, 5'd0, 5'd3, 5'd3);
    e_lw4  = ev(6'b111010, 3'd0, 32'h11C, 32'hBB, 32'hCC,
                32'h4, 6'h04, 5'd1, 5'd4, 5'd4);
    e_ori4 = ev(6'b101000, 3'd3, 32'h120, 32'hDD, 32'hEE,
                32'h10, 6'h10, 5'd2, 5'd4, 5'd4);
    e_beq  = ev(6'b010001, 3'd1, 32'h130, 32'h56, 32'h0,
                32'h3, 6'h03, 5'd5, 5'd0, 5'd0);

    repeat (2) @(posedge clk);

    // addi $8,$9,-4 after reset
    tick(); setid(7'b1011000, 3'd0, 32'h104, 32'h11, 32'h22,
                  16'hFFFC, 5'd9, 5'd8, 5'd31);
    chk(0, 0, 0, z, 0, cexp(0));
    // ori $5,$1,0x8001
    tick(); setid(7'b1001000, 3'd3, 32'h108, 32'h33, 32'h44,
                  16'h8001, 5'd1, 5'd5, 5'd16);
    chk(0, 0, 0, e_addi, 0, cexp(0));
    // lw $5,0($2)
    tick(); setid(7'b1011010, 3'd0, 32'h10C, 32'h55, 32'h66,
                  16'h0, 5'd2, 5'd5, 5'd0);
    chk(0, 0, 0, e_ori5, 0, cexp(0));
    // add $6,$5,$7 -> load-use stall
    tick(); setid(7'b1100000, 3'd2, 32'h110, 32'h77, 32'h88,
                  16'h3020, 5'd5, 5'd7, 5'd6);
    chk(0, 0, 0, ev(6'b111010, 3'd0, 32'h10C, 32'h55, 32'h66,
                    32'h0, 6'h0, 5'd2, 5'd5, 5'd5), 1, cexp(0));
    // add held in ID, bubble in EX
    tick();
    chk(0, 0, 0, z, 0, cexp(1));
    // lw $0,0($3)
    tick(); setid(7'b1011010, 3'd0, 32'h114, 32'h99, 32'h0,
                  16'h0, 5'd3, 5'd0, 5'd0);
    chk(0, 0, 0, e_add, 0, cexp(1));
    // ori $3,$0,1: no hazard on $0
    tick(); setid(7'b1001000, 3'd3, 32'h118, 32'h0, 32'hAA,
                  16'h0001, 5'd0, 5'd3, 5'd0);
    chk(0, 0, 0, e_lw0, 0, cexp(1));
    // lw $4,4($1)
    tick(); setid(7'b1011010, 3'd0, 32'h11C, 32'hBB, 32'hCC,
                  16'h0004, 5'd1, 5'd4, 5'd0);
    chk(0, 0, 0, e_ori3, 0, cexp(1));
    // ori $4,$2,16: rt match only, rt not a source
    tick(); setid(7'b1001000, 3'd3, 32'h120, 32'hDD, 32'hEE,
                  16'h0010, 5'd2, 5'd4, 5'd0);
    chk(0, 0, 0, e_lw4, 0, cexp(1));
    // lw $5 again
    tick(); setid(7'b1011010, 3'd0, 32'h124, 32'h55, 32'h66,
                  16'h0, 5'd2, 5'd5, 5'd0);
    chk(0, 0, 0, e_ori4, 0, cexp(1));
    // sw $5 with flush: flush beats hazard
    tick(); setid(7'b0011100, 3'd0, 32'h128, 32'h12, 32'h34,
                  16'h0, 5'd9, 5'd5, 5'd0);
    chk(0, 0, 1, ev(6'b111010, 3'd0, 32'h124, 32'h55, 32'h66,
                    32'h0, 6'h0, 5'd2, 5'd5, 5'd5), 0, cexp(1));
    // lw $5 after flush bubble
    tick(); setid(7'b1011010, 3'd0, 32'h12C, 32'h55, 32'h66,
                  16'h0, 5'd2, 5'd5, 5'd0);
    chk(0, 0, 0, z, 0, cexp(2));
    // beq $5,$0 with hold: stall suppressed
    tick(); setid(7'b0010001, 3'd1, 32'h130, 32'h56, 32'h0,
                  16'h0003, 5'd5, 5'd0, 5'd0);
    chk(0, 1, 0, ev(6'b111010, 3'd0, 32'h12C, 32'h55, 32'h66,
                    32'h0, 6'h0, 5'd2, 5'd5, 5'd5), 0, cexp(2));
    // hold released: EX unchanged, stall now
    tick();
    chk(0, 0, 0, ev(6'b111010, 3'd0, 32'h12C, 32'h55, 32'h66,
                    32'h0, 6'h0, 5'd2, 5'd5, 5'd5), 1, cexp(2));
    tick();
    chk(0, 0, 0, z, 0, cexp(3));
    // lw $5
    tick(); setid(7'b1011010, 3'd0, 32'h134, 32'h55, 32'h66,
                  16'h0, 5'd2, 5'd5, 5'd0);
    chk(0, 0, 0, e_beq, 0, cexp(3));
    // add with hold
    tick(); setid(7'b1100000, 3'd2, 32'h110, 32'h77, 32'h88,
                  16'h3020, 5'd5, 5'd7, 5'd6);
    chk(0, 1, 0, ev(6'b111010, 3'd0, 32'h134, 32'h55, 32'h66,
                    32'h0, 6'h0, 5'd2, 5'd5, 5'd5), 0, cexp(3));
    // rst while hold
    tick();
    chk(1, 1, 0, ev(6'b111010, 3'd0, 32'h134, 32'h55, 32'h66,
                    32'h0, 6'h0, 5'd2, 5'd5, 5'd5), 0, cexp(3));
    tick();
    chk(0, 0, 0, z, 0, cexp(0));
    // nop
    tick(); setid(7'b0, 3'd0, 32'h0, 32'h0, 32'h0,
                  16'h0, 5'd0, 5'd0, 5'd0);
    chk(0, 0, 0, e_add, 0, cexp(0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
